// File: rtl/max_pool_layer.sv
// Non-overlapping POOL_DIM x POOL_DIM max pooling over an indexed conv output map (IEEE-754 doubles).
// Optional build macro RELU_FUSE_EN: negative pooled maxima are emitted as +0.0 (fused ReLU).
module max_pool_layer #(
    parameter string NAME      = "MAX_POOL_LAYER_DEFAULT_NAME",
    parameter int    CHANNELS  = 1,
    parameter int    IN_DIM    = 3,
    parameter int    POOL_DIM  = 2,
    parameter int    DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [15:0]          rd_index2,
    output logic [15:0]          rd_index1,
    output logic [15:0]          rd_index0,
    input  logic [DATA_SIZE-1:0] rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [15:0]          out_index2,
    output logic [15:0]          out_index1,
    output logic [15:0]          out_index0
);

    localparam int          OUT_DIM = IN_DIM / POOL_DIM;
    localparam bit          EMPTY   = (OUT_DIM == 0);
    localparam logic [15:0] P16     = 16'(POOL_DIM);
    localparam logic [15:0] LAST_K  = 16'(POOL_DIM - 1);
    localparam logic [15:0] LAST_O  = 16'(OUT_DIM - 1);
    localparam logic [15:0] LAST_C  = 16'(CHANNELS - 1);

    if (DATA_SIZE != 64 || POOL_DIM < 1) begin : g_param_check
        $fatal(1, "%s: DATA_SIZE must be 64 and POOL_DIM >= 1", NAME);
    end

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LAST, S_EMIT, S_DONE} state_t;

    state_t               state_reg, state_next;
    logic [15:0]          kx_reg, kx_next, ky_reg, ky_next;
    logic [15:0]          ox_reg, ox_next, oy_reg, oy_next;
    logic [15:0]          ch_reg, ch_next;
    logic [DATA_SIZE-1:0] max_reg;
    logic                 fold_valid_reg, fold_first_reg;

    // Maps doubles onto an unsigned total order: negatives reversed below positives, -0.0 < +0.0.
    function automatic logic [63:0] order_key(input logic [63:0] w);
        return w[63] ? ~w : {1'b1, w[62:0]};
    endfunction

    always_comb begin
        state_next = state_reg;
        kx_next    = kx_reg;
        ky_next    = ky_reg;
        ox_next    = ox_reg;
        oy_next    = oy_reg;
        ch_next    = ch_reg;
        rd_en      = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = EMPTY ? S_DONE : S_RD;
            end
            S_RD: begin
                rd_en = 1'b1;
                if (kx_reg == LAST_K) begin
                    kx_next = '0;
                    if (ky_reg == LAST_K) begin
                        ky_next    = '0;
                        state_next = S_LAST;
                    end else begin
                        ky_next = ky_reg + 16'd1;
                    end
                end else begin
                    kx_next = kx_reg + 16'd1;
                end
            end
            S_LAST: state_next = S_EMIT;
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_RD;
                    if (ox_reg == LAST_O) begin
                        ox_next = '0;
                        if (oy_reg == LAST_O) begin
                            oy_next = '0;
                            if (ch_reg == LAST_C) begin
                                ch_next    = '0;
                                state_next = S_DONE;
                            end else begin
                                ch_next = ch_reg + 16'd1;
                            end
                        end else begin
                            oy_next = oy_reg + 16'd1;
                        end
                    end else begin
                        ox_next = ox_reg + 16'd1;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            kx_reg         <= '0;
            ky_reg         <= '0;
            ox_reg         <= '0;
            oy_reg         <= '0;
            ch_reg         <= '0;
            max_reg        <= '0;
            fold_valid_reg <= 1'b0;
            fold_first_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            kx_reg         <= kx_next;
            ky_reg         <= ky_next;
            ox_reg         <= ox_next;
            oy_reg         <= oy_next;
            ch_reg         <= ch_next;
            // rd_data lags rd_en by one cycle; remember whether that word opens a window.
            fold_valid_reg <= rd_en;
            fold_first_reg <= rd_en && (kx_reg == '0) && (ky_reg == '0);
            if (fold_valid_reg && (fold_first_reg || order_key(rd_data) > order_key(max_reg)))
                max_reg <= rd_data;
        end
    end

    assign busy      = (state_reg == S_RD) || (state_reg == S_LAST) || (state_reg == S_EMIT);
    assign rd_index2 = rd_en ? ch_reg : '0;
    assign rd_index1 = rd_en ? 16'(oy_reg * P16 + ky_reg) : '0;
    assign rd_index0 = rd_en ? 16'(ox_reg * P16 + kx_reg) : '0;

    assign out_index2 = out_valid ? ch_reg : '0;
    assign out_index1 = out_valid ? oy_reg : '0;
    assign out_index0 = out_valid ? ox_reg : '0;
`ifdef RELU_FUSE_EN
    assign out_data = (out_valid && !max_reg[DATA_SIZE-1]) ? max_reg : '0;
`else
    assign out_data = out_valid ? max_reg : '0;
`endif

endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench for max_pool_layer: instance A (1 ch, 4x4) and instance B (2 ch, 5x5 with unread tail).
module tb_max_pool_layer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- instance A: CHANNELS=1, IN_DIM=4, POOL_DIM=2 ----------------
    logic        rst_n_a, start_a, busy_a, done_a, rd_en_a, out_valid_a, out_ready_a;
    logic [15:0] rd_index2_a, rd_index1_a, rd_index0_a, out_index2_a, out_index1_a, out_index0_a;
    logic [63:0] rd_data_a, out_data_a;
    logic [63:0] mem_a [16];

    max_pool_layer #(.NAME("dut_a"), .CHANNELS(1), .IN_DIM(4), .POOL_DIM(2), .DATA_SIZE(64)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .busy(busy_a), .done(done_a),
        .rd_en(rd_en_a), .rd_index2(rd_index2_a), .rd_index1(rd_index1_a), .rd_index0(rd_index0_a),
        .rd_data(rd_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_index2(out_index2_a), .out_index1(out_index1_a), .out_index0(out_index0_a)
    );

    always @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[(int'(rd_index1_a) * 4 + int'(rd_index0_a)) & 15];

    // ---------------- instance B: CHANNELS=2, IN_DIM=5, POOL_DIM=2 ----------------
    logic        rst_n_b, start_b, busy_b, done_b, rd_en_b, out_valid_b, out_ready_b;
    logic [15:0] rd_index2_b, rd_index1_b, rd_index0_b, out_index2_b, out_index1_b, out_index0_b;
    logic [63:0] rd_data_b, out_data_b;
    logic [63:0] mem_b [50];
    int          bad_rd_b = 0;

    max_pool_layer #(.NAME("dut_b"), .CHANNELS(2), .IN_DIM(5), .POOL_DIM(2), .DATA_SIZE(64)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .rd_index2(rd_index2_b), .rd_index1(rd_index1_b), .rd_index0(rd_index0_b),
        .rd_data(rd_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_index2(out_index2_b), .out_index1(out_index1_b), .out_index0(out_index0_b)
    );

    always @(posedge clk) begin
        if (rd_en_b) begin
            rd_data_b <= mem_b[(int'(rd_index2_b) * 25 + int'(rd_index1_b) * 5 + int'(rd_index0_b)) % 50];
            if (rd_index1_b >= 16'd4 || rd_index0_b >= 16'd4 || rd_index2_b >= 16'd2)
                bad_rd_b <= bad_rd_b + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rb(input real r);
        return $realtobits(r);
    endfunction

    function automatic logic [63:0] relu(input logic [63:0] w);
`ifdef RELU_FUSE_EN
        return w[63] ? 64'h0 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [63:0] idx(input int c, input int y, input int x);
        return {16'h0, 16'(c), 16'(y), 16'(x)};
    endfunction

    logic [63:0] cap_d [$];
    logic [63:0] cap_i [$];
    logic [63:0] exp_d [8];
    logic [63:0] exp_i [8];
    int          n, dcount;
    bit          seen;

    initial begin
        rst_n_a = 1'b0; start_a = 1'b0; out_ready_a = 1'b0;
        rst_n_b = 1'b0; start_b = 1'b0; out_ready_b = 1'b0;
        for (int i = 0; i < 16; i++) mem_a[i] = rb(real'(i + 1));
        tick(); tick();

        // reset state
        chk("rst_ctrl", {60'h0, busy_a, done_a, rd_en_a, out_valid_a}, 64'h0);
        chk("rst_data", out_data_a, 64'h0);
        chk("rst_rdidx", {16'h0, rd_index2_a, rd_index1_a, rd_index0_a}, 64'h0);
        chk("rst_outidx", {16'h0, out_index2_a, out_index1_a, out_index0_a}, 64'h0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        tick();

        // test 1: 1..16 map, ready held high, start re-asserted while busy and in DONE
        out_ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("t1_enter_rd", {62'h0, busy_a, rd_en_a}, 64'h3);
        chk("t1_rdidx0", {16'h0, rd_index2_a, rd_index1_a, rd_index0_a}, 64'h0);
        n = 0;
        while (!out_valid_a && n < 20) begin tick(); n++; end
        chk("t1_latency", 64'(n), 64'd5);
        cap_d.delete(); cap_i.delete(); dcount = 0;
        start_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid_a) begin
                cap_d.push_back(out_data_a);
                cap_i.push_back({16'h0, out_index2_a, out_index1_a, out_index0_a});
            end
            if (done_a) begin
                dcount++;
                chk("t1_busy_in_done", {63'h0, busy_a}, 64'h0);
                start_a = 1'b0;
            end
            tick();
        end
        start_a = 1'b0;
        chk("t1_count", 64'(cap_d.size()), 64'd4);
        chk("t1_done_pulses", 64'(dcount), 64'd1);
        chk("t1_idle", {63'h0, busy_a}, 64'h0);
        exp_d[0] = rb(6.0);  exp_i[0] = idx(0, 0, 0);
        exp_d[1] = rb(8.0);  exp_i[1] = idx(0, 0, 1);
        exp_d[2] = rb(14.0); exp_i[2] = idx(0, 1, 0);
        exp_d[3] = rb(16.0); exp_i[3] = idx(0, 1, 1);
        for (int i = 0; i < 4 && i < cap_d.size(); i++) begin
            chk($sformatf("t1_data%0d", i), cap_d[i], exp_d[i]);
            chk($sformatf("t1_idx%0d", i), cap_i[i], exp_i[i]);
        end

        // tests 2+3: negative window, first output stalled for 3 cycles
        for (int i = 0; i < 16; i++) mem_a[i] = rb(-100.0);
        mem_a[0] = rb(-3.0); mem_a[1] = rb(-1.0); mem_a[4] = rb(-2.0); mem_a[5] = rb(-4.0);
        out_ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!out_valid_a && n < 20) begin tick(); n++; end
        chk("t2_valid", {63'h0, out_valid_a}, 64'h1);
        chk("t2_data", out_data_a, relu(rb(-1.0)));
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("t3_hold_valid%0d", s), {63'h0, out_valid_a}, 64'h1);
            chk($sformatf("t3_hold_data%0d", s), out_data_a, relu(rb(-1.0)));
            chk($sformatf("t3_hold_idx%0d", s), {16'h0, out_index2_a, out_index1_a, out_index0_a}, idx(0, 0, 0));
            chk($sformatf("t3_no_rd%0d", s), {63'h0, rd_en_a}, 64'h0);
        end
        out_ready_a = 1'b1;
        tick();
        chk("t3_released", {63'h0, out_valid_a}, 64'h0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (done_a) seen = 1'b1;
        end
        chk("t2_done", {63'h0, seen}, 64'h1);
        tick();

        // test 6: reset in the middle of the second window's reads, then rerun
        for (int i = 0; i < 16; i++) mem_a[i] = rb(real'(i + 1));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!out_valid_a && n < 20) begin tick(); n++; end
        tick();
        tick();
        chk("t6_mid_rd", {47'h0, rd_en_a, rd_index0_a}, {47'h0, 1'b1, 16'd3});
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;
        chk("t6_rst_ctrl", {60'h0, busy_a, done_a, rd_en_a, out_valid_a}, 64'h0);
        chk("t6_rst_data", out_data_a, 64'h0);
        chk("t6_rst_idx", {16'h0, rd_index2_a | out_index2_a, rd_index1_a | out_index1_a,
                           rd_index0_a | out_index0_a}, 64'h0);
        tick();
        chk("t6_stays_idle", {62'h0, busy_a, rd_en_a}, 64'h0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("t6_restart_idx", {15'h0, rd_en_a, rd_index2_a, rd_index1_a, rd_index0_a}, {15'h0, 1'b1, 48'h0});
        n = 0;
        while (!out_valid_a && n < 20) begin tick(); n++; end
        chk("t6_latency", 64'(n), 64'd5);
        chk("t6_data", out_data_a, rb(6.0));
        chk("t6_idx", {16'h0, out_index2_a, out_index1_a, out_index0_a}, idx(0, 0, 0));
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (done_a) seen = 1'b1;
        end
        chk("t6_done", {63'h0, seen}, 64'h1);

        // tests 4+5: two channels, 5x5 maps with an unread trailing row/column
        for (int i = 0; i < 50; i++) mem_b[i] = rb(-50.0);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                mem_b[y * 5 + x] = (y == 4 || x == 4) ? rb(1000.0) : rb(real'(y * 5 + x + 1));
        mem_b[25 + 0] = rb(-5.0); mem_b[25 + 1] = rb(9.0);
        mem_b[25 + 5] = rb(0.0);  mem_b[25 + 6] = 64'h8000_0000_0000_0000;
        mem_b[25 + 2] = 64'h8000_0000_0000_0000; mem_b[25 + 3] = 64'h0;
        mem_b[25 + 7] = 64'h8000_0000_0000_0000; mem_b[25 + 8] = 64'h8000_0000_0000_0000;
        mem_b[25 + 10] = rb(-7.0); mem_b[25 + 11] = rb(-7.0);
        mem_b[25 + 15] = rb(-8.0); mem_b[25 + 16] = rb(-9.0);
        mem_b[25 + 12] = rb(-1.0); mem_b[25 + 13] = rb(-2.0);
        mem_b[25 + 17] = rb(-3.0); mem_b[25 + 18] = rb(0.5);
        exp_d[0] = rb(7.0);  exp_i[0] = idx(0, 0, 0);
        exp_d[1] = rb(9.0);  exp_i[1] = idx(0, 0, 1);
        exp_d[2] = rb(17.0); exp_i[2] = idx(0, 1, 0);
        exp_d[3] = rb(19.0); exp_i[3] = idx(0, 1, 1);
        exp_d[4] = rb(9.0);  exp_i[4] = idx(1, 0, 0);
        exp_d[5] = 64'h0;    exp_i[5] = idx(1, 0, 1);
        exp_d[6] = relu(rb(-7.0)); exp_i[6] = idx(1, 1, 0);
        exp_d[7] = rb(0.5);  exp_i[7] = idx(1, 1, 1);
        out_ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cap_d.delete(); cap_i.delete(); dcount = 0;
        for (int i = 0; i < 120; i++) begin
            if (out_valid_b) begin
                cap_d.push_back(out_data_b);
                cap_i.push_back({16'h0, out_index2_b, out_index1_b, out_index0_b});
            end
            if (done_b) dcount++;
            tick();
        end
        chk("t4_count", 64'(cap_d.size()), 64'd8);
        chk("t4_done_pulses", 64'(dcount), 64'd1);
        chk("t4_no_tail_reads", 64'(bad_rd_b), 64'd0);
        for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
            chk($sformatf("t45_data%0d", i), cap_d[i], exp_d[i]);
            chk($sformatf("t45_idx%0d", i), cap_i[i], exp_i[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
